// File: rtl/ps2_pkg.sv
// PS/2 scancode decoder shared types and constants.
// Optional repeat filtering is enabled with PS2_REPEAT_FILTER_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } ps2_dec_state_t;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_OVERRUN = 8'h00;
  localparam logic [7:0] SC_ERROR   = 8'hFF;
  localparam logic [7:0] SC_SPACE   = 8'h29;

endpackage

// File: rtl/ps2_scancode_decoder_sync_rise.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Used to bring the receiver's byte-ready level into the clk domain.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q_rise
);

  logic [2:0] s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= {s_q[1:0], d};
    end
  end

  assign q_rise = s_q[1] & ~s_q[2];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode byte stream to key-event decoder with flap tracking.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeat makes.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int         ACK_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] FLAP_CODE      = SC_SPACE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       received,
  input  logic [7:0] received_data,
  output logic       read_ack,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       flap_pressed,
  output logic       prefix_timeout
);

  localparam int AW = $clog2(ACK_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic           rise;
  logic [7:0]     byte_q;
  logic           byte_vld_q;
  logic [AW-1:0]  ack_cnt_q, ack_cnt_d;
  ps2_dec_state_t state_q, state_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic           to_fire;
  logic           ev, ev_rel, ev_ext, emit;
  logic           key_valid_q, key_release_q, key_ext_q;
  logic [7:0]     key_code_q;
  logic           flap_q, to_q;
  logic           is_pfx, is_bad;

  sync_rise u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (received),
    .q_rise (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      ack_cnt_q  <= '0;
    end else begin
      byte_vld_q <= rise;
      ack_cnt_q  <= ack_cnt_d;
      if (rise) byte_q <= received_data;
    end
  end

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    if (rise)                ack_cnt_d = ACK_LOAD;
    else if (ack_cnt_q != 0) ack_cnt_d = ack_cnt_q - AW'(1);
  end

  assign read_ack = (ack_cnt_q != '0);

  assign is_bad = (byte_q == SC_OVERRUN) || (byte_q == SC_ERROR);
  assign is_pfx = (byte_q == SC_EXT) || (byte_q == SC_BREAK);

  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    to_fire  = 1'b0;
    ev       = 1'b0;
    ev_rel   = 1'b0;
    ev_ext   = 1'b0;
    if (byte_vld_q) begin
      if (is_bad) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (byte_q == SC_EXT)        state_d = S_EXT;
            else if (byte_q == SC_BREAK) state_d = S_BRK;
            else                         ev = 1'b1;
          end
          S_EXT: begin
            if (byte_q == SC_BREAK) begin
              state_d = S_EXT_BRK;
            end else if (byte_q != SC_EXT) begin
              state_d = S_IDLE;
              ev      = 1'b1;
              ev_ext  = 1'b1;
            end
          end
          S_BRK: begin
            state_d = S_IDLE;
            ev      = !is_pfx;
            ev_rel  = 1'b1;
          end
          S_EXT_BRK: begin
            state_d = S_IDLE;
            ev      = !is_pfx;
            ev_rel  = 1'b1;
            ev_ext  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = S_IDLE;
        to_fire = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] lm_code_q;
  logic       lm_ext_q, lm_vld_q;
  logic       lm_hit;

  assign lm_hit = (lm_code_q == byte_q) && (lm_ext_q == ev_ext);
  assign emit   = ev && !(!ev_rel && lm_vld_q && lm_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lm_code_q <= '0;
      lm_ext_q  <= 1'b0;
      lm_vld_q  <= 1'b0;
    end else if (ev) begin
      if (ev_rel) begin
        if (lm_hit) lm_vld_q <= 1'b0;
      end else if (emit) begin
        lm_code_q <= byte_q;
        lm_ext_q  <= ev_ext;
        lm_vld_q  <= 1'b1;
      end
    end
  end
`else
  assign emit = ev;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      to_cnt_q      <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_release_q <= 1'b0;
      key_ext_q     <= 1'b0;
      flap_q        <= 1'b0;
      to_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      key_valid_q <= emit;
      to_q        <= to_fire;
      if (emit) begin
        key_code_q    <= byte_q;
        key_release_q <= ev_rel;
        key_ext_q     <= ev_ext;
      end
      // Flap follows decoded events, so repeat filtering never affects it
      if (ev && !ev_ext && byte_q == FLAP_CODE) flap_q <= !ev_rel;
    end
  end

  assign key_valid      = key_valid_q;
  assign key_code       = key_code_q;
  assign key_release    = key_release_q;
  assign key_extended   = key_ext_q;
  assign flap_pressed   = flap_q;
  assign prefix_timeout = to_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed bench for ps2_scancode_decoder.
// Reference model decodes byte sequences by prefix flags.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       received = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       read_ack, key_valid, key_release, key_extended;
  logic       flap_pressed, prefix_timeout;
  logic [7:0] key_code;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int ack_n = 0;
  int to_n = 0;

  typedef struct {
    logic [7:0] code;
    logic       rel;
    logic       ext;
    int         at;
  } ev_t;
  ev_t evq[$];

  // model state
  logic       m_e0 = 0, m_f0 = 0, m_flap = 0;
  logic [7:0] m_kcode = 0;
  logic       m_krel = 0, m_kext = 0;
  logic [7:0] m_lcode = 0;
  logic       m_lext = 0, m_lvld = 0;

  ps2_scancode_decoder #(
    .ACK_CYCLES     (4),
    .TIMEOUT_CYCLES (16),
    .FLAP_CODE      (8'h29)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .received       (received),
    .received_data  (received_data),
    .read_ack       (read_ack),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_release    (key_release),
    .key_extended   (key_extended),
    .flap_pressed   (flap_pressed),
    .prefix_timeout (prefix_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_valid) evq.push_back('{key_code, key_release, key_extended, cyc});
    if (read_ack) ack_n++;
    if (prefix_timeout) to_n++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_e0 = 0; m_f0 = 0; m_flap = 0;
    m_kcode = 0; m_krel = 0; m_kext = 0;
    m_lcode = 0; m_lext = 0; m_lvld = 0;
  endtask

  // Returns whether a key_valid strobe is expected for this byte.
  task automatic model_byte(input logic [7:0] b, output logic emit,
                            output logic rel, output logic ext);
    logic dec;
    dec = 0; emit = 0; rel = m_f0; ext = m_e0;
    if (b == 8'h00 || b == 8'hFF) begin
      m_e0 = 0; m_f0 = 0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (m_f0) begin
        m_e0 = 0; m_f0 = 0;
      end else if (b == 8'hE0) m_e0 = 1;
      else m_f0 = 1;
    end else begin
      dec = 1; m_e0 = 0; m_f0 = 0;
    end
    if (dec) begin
      emit = 1;
`ifdef PS2_REPEAT_FILTER_EN
      if (rel) begin
        if (m_lcode == b && m_lext == ext) m_lvld = 0;
      end else if (m_lvld && m_lcode == b && m_lext == ext) begin
        emit = 0;
      end else begin
        m_lcode = b; m_lext = ext; m_lvld = 1;
      end
`endif
      if (b == 8'h29 && !ext) m_flap = !rel;
      if (emit) begin
        m_kcode = b; m_krel = rel; m_kext = ext;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    evq.delete();
    ack_n = 0;
    to_n = 0;
    @(negedge clk);
    received_data = b;
    received = 1'b1;
    rise_cyc = cyc;
    repeat (8) @(negedge clk);
    received = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_chk(input logic [7:0] b);
    logic e, r, x;
    send(b);
    model_byte(b, e, r, x);
    check("ev_count", evq.size(), int'(e));
    if (evq.size() == 1 && e) begin
      check("ev_code", evq[0].code, b);
      check("ev_rel", evq[0].rel, r);
      check("ev_ext", evq[0].ext, x);
      check("latency", evq[0].at - rise_cyc, 4);
    end
    check("ack_len", ack_n, 4);
    check("no_timeout", to_n, 0);
    check("flap", flap_pressed, m_flap);
    check("held_code", key_code, m_kcode);
    check("held_rel", key_release, m_krel);
    check("held_ext", key_extended, m_kext);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ack", read_ack, 0);
    check("rst_flap", flap_pressed, 0);
    check("rst_to", prefix_timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_chk(8'h29);
    send_chk(8'hF0);
    send_chk(8'h29);
    send_chk(8'hE0); send_chk(8'hF0); send_chk(8'h75);
    send_chk(8'h29);
    send_chk(8'hE0); send_chk(8'h29);
    check("flap_ext_nochg", flap_pressed, 1);

    send_chk(8'hE0);
    repeat (30) @(negedge clk);
    check("timeout_once", to_n, 1);
    check("timeout_noev", evq.size(), 0);
    m_e0 = 0; m_f0 = 0;
    send_chk(8'h1C);
    check("after_to_ext", key_extended, 0);

    send_chk(8'h75);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      b = (i == 3) ? 8'hF0 : 8'h1C;
      send_chk(b);
      n += evq.size();
    end
`ifdef PS2_REPEAT_FILTER_EN
    check("repeat_events", n, 2);
`else
    check("repeat_events", n, 4);
`endif

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h29;
        3: b = 8'h1C;
        4: b = 8'h75;
        5: b = 8'h00;
        6: b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      send_chk(b);
    end

    send_chk(8'h29);
    send_chk(8'hF0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_rel", key_release, 0);
    check("mid_rst_ext", key_extended, 0);
    check("mid_rst_flap", flap_pressed, 0);
    check("mid_rst_ack", read_ack, 0);
    check("mid_rst_to", prefix_timeout, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_chk(8'h29);
    check("post_rst_make", key_release, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes raw bytes from the PS/2 receiver and turns them into one-cycle key events: code, make/break, extended flag.
- Runs on the system clock and moves each byte across from the PS2_CLK domain with a synchroniser.
- Returns `read_ack` to the receiver for each byte it takes.
- Also drives a level `flap_pressed` for the game logic, tracking the space key (make 0x29, break F0 29).

Parameters:
- ACK_CYCLES, 4, width of the `read_ack` pulse in clk cycles. Must be ≥1. Sized so the receiver's asynchronous ack input is seen as a clean pulse.
- TIMEOUT_CYCLES, 1_000_000, clk cycles a pending prefix (E0/F0) may wait before it is discarded.
- FLAP_CODE, 8'h29, scancode that drives `flap_pressed`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- received  in  1  byte-ready level from the receiver (PS2_CLK domain)
- received_data  in  8  byte from the receiver. Stable while `received` is high.
- read_ack  out  1  acknowledge pulse back to the receiver
- key_valid  out  1  one-cycle key-event strobe
- key_code  out  8  scancode of the event. Held until the next event.
- key_release  out  1  1 = break event, 0 = make event. Valid with `key_valid`.
- key_extended  out  1  1 = code was preceded by E0. Valid with `key_valid`.
- flap_pressed  out  1  level, high while FLAP_CODE (non-extended) is held
- prefix_timeout  out  1  one-cycle strobe when a pending prefix is discarded

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM in S_IDLE, ack counter and timeout counter 0.
- Input path:
  - `received` passes through a 2-FF synchroniser, then rising-edge detect.
  - On the edge, `received_data` is latched into `byte_q`.
  - `read_ack` is then driven high for exactly ACK_CYCLES cycles, starting the cycle after the edge.
  - A new edge while `read_ack` is high is processed normally and the ack counter restarts.
- Byte latency: a byte that completes an event raises `key_valid` 1 cycle after capture, i.e. 4 clk cycles after `received` rises.
- FSM, evaluated on each captured byte:
  - S_IDLE:
    - E0 → S_EXT
    - F0 → S_BRK
    - any other byte → emit make, extended=0, stay in S_IDLE
  - S_EXT:
    - F0 → S_EXT_BRK
    - E0 → stay in S_EXT
    - other byte → emit make, extended=1, go to S_IDLE
  - S_BRK:
    - E0 or F0 → discard, go to S_IDLE
    - other byte → emit break, extended=0, go to S_IDLE
  - S_EXT_BRK:
    - E0 or F0 → discard, go to S_IDLE
    - other byte → emit break, extended=1, go to S_IDLE
- Byte 0x00 (keyboard overrun) or 0xFF (error): in any state, go to S_IDLE with no event.
- Timeout:
  - In any state other than S_IDLE, a counter increments every cycle and clears on each captured byte.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to S_IDLE and `prefix_timeout` pulses for 1 cycle.
  - A byte captured in the same cycle as the timeout wins: it is decoded and no timeout is signalled.
- `flap_pressed`:
  - Set on a make event with code FLAP_CODE and extended=0.
  - Cleared on the matching break event.
  - Extended events with the same code do not affect it.
- Event outputs: `key_code`, `key_release` and `key_extended` update only when `key_valid` is high.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined:
  - The block keeps `last_make` (8 bits plus extended bit, plus a valid flag).
  - A make event equal to `last_make` while its valid flag is set is suppressed: no `key_valid` strobe.
  - A break event whose code and extended bit match `last_make` clears the valid flag.
  - Any other make event overwrites `last_make`.
  - Net effect: typematic repeats are filtered out.
- Undefined: every decoded make event is emitted, repeats included. `flap_pressed` behaviour is identical in both builds.

Decomposition:
- Package `ps2_pkg` holds:
  - the state enum `ps2_dec_state_t` (S_IDLE, S_EXT, S_BRK, S_EXT_BRK);
  - the constants SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_OVERRUN=8'h00, SC_ERROR=8'hFF, SC_SPACE=8'h29.
- One sub-module is natural: `sync_rise`. It is the 2-FF synchroniser plus rising-edge detect, with ports clk, rst_n, d, q_rise.

Test Plan:
- Byte 29 → `key_valid` pulses once, `key_code`=29, `key_release`=0, `key_extended`=0, `flap_pressed`=1. `read_ack` is high for 4 cycles.
- Bytes F0,29 → one `key_valid` with `key_release`=1, `key_code`=29; `flap_pressed` drops to 0. The F0 byte alone gives no strobe.
- Bytes E0,F0,75 → one event: `key_code`=75, `key_release`=1, `key_extended`=1. Bytes E0,29 → `flap_pressed` unchanged.
- Byte E0, then no bytes for TIMEOUT_CYCLES (bench sets it to 16) → `prefix_timeout` pulses once. A following byte 1C gives a make with `key_extended`=0.
- Bytes 1C,1C,1C,F0,1C:
  - PS2_REPEAT_FILTER_EN defined → 2 events (make, break).
  - Undefined → 4 events.
- rst_n pulled low mid-sequence after F0 → all outputs 0 immediately. A following byte 29 gives a make, not a break.
